// File: rtl/shift_add_mult_ctrl.sv
// Sequential unsigned shift-and-add multiplier.
// A one-hot controller (T0 idle, T1 add, T2 shift, T3 done) sequences a
// datapath of multiplicand MD, multiplier MR, accumulator ACC and product P.
// The loop stops as soon as the remaining multiplier bits are all zero, so
// the latency depends on the position of the highest set bit of B.
module shift_add_mult_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 S,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic [2*WIDTH-1:0]   P,
  output logic                 BUSY,
  output logic                 DONE,
  output logic [3:0]           STATE
);

  // One-hot state constants {T3,T2,T1,T0}
  localparam logic [3:0] T0 = 4'b0001;
  localparam logic [3:0] T1 = 4'b0010;
  localparam logic [3:0] T2 = 4'b0100;
  localparam logic [3:0] T3 = 4'b1000;

  logic [3:0]         state_q, state_d;
  logic [2*WIDTH-1:0] md_q, md_d;
  logic [WIDTH-1:0]   mr_q, mr_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] p_q, p_d;
  logic               z;

  // Multiplier is exhausted once the bits that survive the shift are all zero
  assign z = (mr_q[WIDTH-1:1] == '0);

  // Next-state and datapath control
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    state_d = state_q;
    md_d    = md_q;
    mr_d    = mr_q;
    acc_d   = acc_q;
    p_d     = p_q;
    case (state_q)
      T0: begin
        if (S) begin
          md_d    = {{WIDTH{1'b0}}, A};
          mr_d    = B;
          acc_d   = '0;
          state_d = T1;
        end
      end
      T1: begin
        if (mr_q[0]) begin
          acc_d = acc_q + md_q;
        end
        state_d = T2;
      end
      T2: begin
        md_d = md_q << 1;
        mr_d = mr_q >> 1;
        if (z) begin
          p_d     = acc_q;
          state_d = T3;
        end else begin
          state_d = T1;
        end
      end
      T3: begin
        state_d = T0;
      end
      default: begin
        // Illegal encoding: fall back to idle
        state_d = T0;
      end
    endcase
  end

  // State and datapath registers with asynchronous reset
  always_ff @(posedge CLK or posedge RST) begin
    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from values sampled at the same edge.
    if (RST) begin
      state_q <= T0;
      md_q    <= '0;
      mr_q    <= '0;
      acc_q   <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      md_q    <= md_d;
      mr_q    <= mr_d;
      acc_q   <= acc_d;
      p_q     <= p_d;
    end
  end

  assign P     = p_q;
  assign BUSY  = state_q[1] | state_q[2];
  assign DONE  = state_q[3];
  assign STATE = state_q;

endmodule
